// File: rtl/tank_pkg.sv
// Shared turret types: compass directions, FSM states and rotation helpers.
// Clockwise order is U -> R -> D -> L -> U.
package tank_pkg;

   typedef enum logic [1:0] {
      DIR_L = 2'b00,
      DIR_R = 2'b01,
      DIR_D = 2'b10,
      DIR_U = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROTATE,
      ST_RECOIL,
      ST_COOLDOWN
   } turret_state_t;

   function automatic dir_t dir_cw(input dir_t d);
      case (d)
         DIR_U:   dir_cw = DIR_R;
         DIR_R:   dir_cw = DIR_D;
         DIR_D:   dir_cw = DIR_L;
         default: dir_cw = DIR_U;
      endcase
   endfunction

   function automatic dir_t dir_ccw(input dir_t d);
      case (d)
         DIR_U:   dir_ccw = DIR_L;
         DIR_L:   dir_ccw = DIR_D;
         DIR_D:   dir_ccw = DIR_R;
         default: dir_ccw = DIR_U;
      endcase
   endfunction

   // Half-turns resolve clockwise; only an exact ccw neighbour goes ccw.
   function automatic dir_t dir_step_toward(input dir_t cur, input dir_t tgt);
      if (tgt == cur)
         dir_step_toward = cur;
      else if (tgt == dir_ccw(cur))
         dir_step_toward = dir_ccw(cur);
      else
         dir_step_toward = dir_cw(cur);
   endfunction

endpackage

// File: rtl/barrel_geometry.sv
// Combinational barrel rectangle and muzzle point from direction and offset.
// All arithmetic wraps modulo 2^COORD_W.
module barrel_geometry
   import tank_pkg::*;
#(
   parameter int COORD_W    = 10,
   parameter int LONG_HALF  = 6,
   parameter int SHORT_HALF = 4
) (
   input  dir_t               dir,
   input  logic [COORD_W-1:0] ball_x,
   input  logic [COORD_W-1:0] ball_y,
   input  logic [COORD_W-1:0] off,
   output logic [COORD_W-1:0] barrel_x,
   output logic [COORD_W-1:0] barrel_y,
   output logic [COORD_W-1:0] len,
   output logic [COORD_W-1:0] hgt,
   output logic [COORD_W-1:0] muzzle_x,
   output logic [COORD_W-1:0] muzzle_y
);

   localparam logic [COORD_W-1:0] LONG  = COORD_W'(LONG_HALF);
   localparam logic [COORD_W-1:0] SHORT = COORD_W'(SHORT_HALF);

   always_comb begin
      barrel_x = ball_x;
      barrel_y = ball_y;
      len      = LONG;
      hgt      = SHORT;
      muzzle_x = ball_x;
      muzzle_y = ball_y;
      case (dir)
         DIR_L: begin
            barrel_x = ball_x - off;
            len      = SHORT;
            hgt      = LONG;
            muzzle_x = ball_x - off - SHORT;
         end
         DIR_R: begin
            barrel_x = ball_x + off;
            len      = SHORT;
            hgt      = LONG;
            muzzle_x = ball_x + off + SHORT;
         end
         DIR_D: begin
            barrel_y = ball_y + off;
            muzzle_y = ball_y + off + SHORT;
         end
         default: begin
            barrel_y = ball_y - off;
            muzzle_y = ball_y - off - SHORT;
         end
      endcase
   end

endmodule

// File: rtl/tank_turret.sv
// Per-tank turret: quarter-step rotation, fire gating, cooldown and registered barrel geometry.
// Define TANK_TURRET_RECOIL_EN to add the RECOIL state and barrel retraction.
module tank_turret
   import tank_pkg::*;
#(
   parameter int         COORD_W         = 10,
   parameter int         LONG_HALF       = 6,
   parameter int         SHORT_HALF      = 4,
   parameter int         GAP             = 3,
   parameter int         ROT_FRAMES      = 4,
   parameter int         RECOIL_PX       = 2,
   parameter int         RECOIL_FRAMES   = 6,
   parameter int         COOLDOWN_FRAMES = 30,
   parameter logic [1:0] RESET_DIR       = 2'b11
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic [COORD_W-1:0] BallX,
   input  logic [COORD_W-1:0] BallY,
   input  logic [COORD_W-1:0] Ball_Size,
   input  logic [1:0]         p_direction,
   input  logic               fire,
   output logic [COORD_W-1:0] BarrelX,
   output logic [COORD_W-1:0] BarrelY,
   output logic [COORD_W-1:0] Barrel_Length_Halved,
   output logic [COORD_W-1:0] Barrel_Height_Halved,
   output logic [COORD_W-1:0] MuzzleX,
   output logic [COORD_W-1:0] MuzzleY,
   output logic [1:0]         cur_direction,
   output logic               rotating,
   output logic               fire_ready,
   output logic               shot_fire
);

   localparam int CNT_A   = (ROT_FRAMES > RECOIL_FRAMES) ? ROT_FRAMES : RECOIL_FRAMES;
   localparam int CNT_MAX = (CNT_A > COOLDOWN_FRAMES) ? CNT_A : COOLDOWN_FRAMES;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] ROT_LAST = CNT_W'(ROT_FRAMES - 1);
   localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COOLDOWN_FRAMES - 1);
   localparam turret_state_t    AFTER_SHOT_CD =
      (COOLDOWN_FRAMES == 0) ? ST_IDLE : ST_COOLDOWN;
   localparam logic [COORD_W-1:0] GAP_W    = COORD_W'(GAP);
   localparam logic [COORD_W-1:0] RECOIL_W = COORD_W'(RECOIL_PX);

   turret_state_t      state, state_n;
   dir_t               cur_dir, dir_n, cmd_dir;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               shot_n, aligned, in_recoil;
   logic [COORD_W-1:0] off;
   logic [COORD_W-1:0] g_x, g_y, g_len, g_hgt, g_mx, g_my;

   assign cmd_dir       = dir_t'(p_direction);
   assign aligned       = (cur_dir == cmd_dir);
   assign cur_direction = cur_dir;
   assign rotating      = (state == ST_ROTATE);
   assign fire_ready    = (state == ST_IDLE) && aligned;

`ifdef TANK_TURRET_RECOIL_EN
   localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOIL_FRAMES - 1);
   localparam turret_state_t    AFTER_FIRE = ST_RECOIL;
   assign in_recoil = (state == ST_RECOIL);
`else
   localparam turret_state_t    AFTER_FIRE = AFTER_SHOT_CD;
   assign in_recoil = 1'b0;
`endif

   assign off = Ball_Size + GAP_W - (in_recoil ? RECOIL_W : '0);

   barrel_geometry #(
      .COORD_W    (COORD_W),
      .LONG_HALF  (LONG_HALF),
      .SHORT_HALF (SHORT_HALF)
   ) u_geom (
      .dir      (cur_dir),
      .ball_x   (BallX),
      .ball_y   (BallY),
      .off      (off),
      .barrel_x (g_x),
      .barrel_y (g_y),
      .len      (g_len),
      .hgt      (g_hgt),
      .muzzle_x (g_mx),
      .muzzle_y (g_my)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      dir_n   = cur_dir;
      shot_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_n = '0;
            if (!aligned) begin
               state_n = ST_ROTATE;
            end else if (fire) begin
               shot_n  = 1'b1;
               state_n = AFTER_FIRE;
            end
         end
         ST_ROTATE: begin
            // Alignment is checked before stepping so a reverted command stops early.
            if (aligned) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else if (cnt == ROT_LAST) begin
               dir_n = dir_step_toward(cur_dir, cmd_dir);
               cnt_n = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef TANK_TURRET_RECOIL_EN
         ST_RECOIL: begin
            if (cnt == REC_LAST) begin
               state_n = AFTER_SHOT_CD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`endif
         ST_COOLDOWN: begin
            if (cnt == CD_LAST) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state                <= ST_IDLE;
         cnt                  <= '0;
         cur_dir              <= dir_t'(RESET_DIR);
         shot_fire            <= 1'b0;
         BarrelX              <= '0;
         BarrelY              <= '0;
         Barrel_Length_Halved <= '0;
         Barrel_Height_Halved <= '0;
         MuzzleX              <= '0;
         MuzzleY              <= '0;
      end else begin
         state                <= state_n;
         cnt                  <= cnt_n;
         cur_dir              <= dir_n;
         shot_fire            <= shot_n;
         BarrelX              <= g_x;
         BarrelY              <= g_y;
         Barrel_Length_Halved <= g_len;
         Barrel_Height_Halved <= g_hgt;
         MuzzleX              <= g_mx;
         MuzzleY              <= g_my;
      end
   end

endmodule

// File: tb/tb_tank_turret.sv
// Directed bench for tank_turret: reset, rotation paths, shot timing, async reset, wrap.
// Expected shot period follows TANK_TURRET_RECOIL_EN.
module tb_tank_turret;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [9:0] BallX, BallY, Ball_Size;
   logic [1:0] p_direction;
   logic       fire;
   logic [9:0] BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved;
   logic [9:0] MuzzleX, MuzzleY;
   logic [1:0] cur_direction;
   logic       rotating, fire_ready, shot_fire;

   int vectors     = 0;
   int miscompares = 0;

`ifdef TANK_TURRET_RECOIL_EN
   localparam int PERIOD = 37;
   localparam int REC_Y  = 223;
`else
   localparam int PERIOD = 31;
   localparam int REC_Y  = 221;
`endif

   always #5 frame_clk = ~frame_clk;

   tank_turret dut (
      .frame_clk            (frame_clk),
      .Reset                (Reset),
      .BallX                (BallX),
      .BallY                (BallY),
      .Ball_Size            (Ball_Size),
      .p_direction          (p_direction),
      .fire                 (fire),
      .BarrelX              (BarrelX),
      .BarrelY              (BarrelY),
      .Barrel_Length_Halved (Barrel_Length_Halved),
      .Barrel_Height_Halved (Barrel_Height_Halved),
      .MuzzleX              (MuzzleX),
      .MuzzleY              (MuzzleY),
      .cur_direction        (cur_direction),
      .rotating             (rotating),
      .fire_ready           (fire_ready),
      .shot_fire            (shot_fire)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge frame_clk);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b1; BallX = 10'd320; BallY = 10'd240; Ball_Size = 10'd16;
      p_direction = 2'b11; fire = 1'b0;
      #1;
      vectors++;
      if ({BarrelX, BarrelY, MuzzleX, MuzzleY, shot_fire, rotating} !== 42'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got %0d,%0d muz %0d,%0d shot %b rot %b want all 0",
                  BarrelX, BarrelY, MuzzleX, MuzzleY, shot_fire, rotating);
      end
      vectors++;
      if (cur_direction !== 2'b11) begin
         miscompares++;
         $display("FAIL reset_dir got %b want 11", cur_direction);
      end
      tick(1);
      Reset = 1'b0;
      tick(1);
      vectors++;
      if ({BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY}
          !== {10'd320, 10'd221, 10'd6, 10'd4, 10'd320, 10'd217}) begin
         miscompares++;
         $display("FAIL geom_up got %0d,%0d %0d %0d muz %0d,%0d want 320,221 6 4 muz 320,217",
                  BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY);
      end
      vectors++;
      if (fire_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL ready_up got %b want 1", fire_ready);
      end
   endtask

   task automatic test_rotate_quarter;
      p_direction = 2'b01;
      tick(1);
      vectors++;
      if ({rotating, cur_direction} !== 3'b1_11) begin
         miscompares++;
         $display("FAIL rot_start got rot %b dir %b want 1 11", rotating, cur_direction);
      end
      tick(3);
      vectors++;
      if (cur_direction !== 2'b11) begin
         miscompares++;
         $display("FAIL rot_early got %b want 11", cur_direction);
      end
      tick(1);
      vectors++;
      if ({rotating, cur_direction} !== 3'b1_01) begin
         miscompares++;
         $display("FAIL rot_step got rot %b dir %b want 1 01", rotating, cur_direction);
      end
      tick(1);
      vectors++;
      if ({rotating, fire_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL rot_done got rot %b ready %b want 0 1", rotating, fire_ready);
      end
      vectors++;
      if ({BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY}
          !== {10'd339, 10'd240, 10'd4, 10'd6, 10'd343, 10'd240}) begin
         miscompares++;
         $display("FAIL geom_r got %0d,%0d %0d %0d muz %0d,%0d want 339,240 4 6 muz 343,240",
                  BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY);
      end
      p_direction = 2'b11;
      tick(5);
      vectors++;
      if (cur_direction !== 2'b11) begin
         miscompares++;
         $display("FAIL rot_ccw got %b want 11", cur_direction);
      end
      tick(1);
   endtask

   task automatic test_rotate_half;
      int shots = 0;
      p_direction = 2'b10;
      fire = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         if (shot_fire === 1'b1) shots++;
         if (k == 5) begin
            vectors++;
            if (cur_direction !== 2'b01) begin
               miscompares++;
               $display("FAIL half_mid got %b want 01", cur_direction);
            end
         end
         if (k == 9) begin
            vectors++;
            if (cur_direction !== 2'b10) begin
               miscompares++;
               $display("FAIL half_end got %b want 10", cur_direction);
            end
         end
      end
      fire = 1'b0;
      vectors++;
      if ({shots, rotating} !== {32'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL half_noshot got shots %0d rot %b want 0 0", shots, rotating);
      end
      vectors++;
      if ({BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY}
          !== {10'd320, 10'd259, 10'd6, 10'd4, 10'd320, 10'd263}) begin
         miscompares++;
         $display("FAIL geom_d got %0d,%0d %0d %0d muz %0d,%0d want 320,259 6 4 muz 320,263",
                  BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY);
      end
      p_direction = 2'b11;
      tick(5);
      vectors++;
      if (cur_direction !== 2'b00) begin
         miscompares++;
         $display("FAIL half_d2u got %b want 00", cur_direction);
      end
      tick(5);
      vectors++;
      if ({rotating, cur_direction} !== 3'b0_11) begin
         miscompares++;
         $display("FAIL half_back got rot %b dir %b want 0 11", rotating, cur_direction);
      end
   endtask

   task automatic test_single_shot;
      int got = -1;
      fire = 1'b1;
      tick(1);
      fire = 1'b0;
      vectors++;
      if ({shot_fire, fire_ready} !== 2'b10) begin
         miscompares++;
         $display("FAIL shot_pulse got shot %b ready %b want 1 0", shot_fire, fire_ready);
      end
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         vectors++;
         if (BarrelY !== ((k <= 6) ? 10'(REC_Y) : 10'd221)) begin
            miscompares++;
            $display("FAIL recoil_y frame %0d got %0d want %0d", k, BarrelY,
                     (k <= 6) ? REC_Y : 221);
         end
         if (k == 1) begin
            vectors++;
            if (shot_fire !== 1'b0) begin
               miscompares++;
               $display("FAIL shot_width got %b want 0", shot_fire);
            end
         end
      end
      fire = 1'b1;
      for (int k = 8; k < 200 && got < 0; k++) begin
         tick(1);
         if (shot_fire === 1'b1) got = k;
      end
      vectors++;
      if (got !== PERIOD) begin
         miscompares++;
         $display("FAIL shot_block got next shot at %0d want %0d", got, PERIOD);
      end
   endtask

   task automatic test_back_to_back;
      for (int r = 0; r < 2; r++) begin
         int got = -1;
         for (int k = 1; k <= PERIOD + 5 && got < 0; k++) begin
            tick(1);
            if (shot_fire === 1'b1) got = k;
         end
         vectors++;
         if (got !== PERIOD) begin
            miscompares++;
            $display("FAIL b2b_period rep %0d got %0d want %0d", r, got, PERIOD);
         end
      end
      fire = 1'b0;
      tick(PERIOD);
      vectors++;
      if (fire_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_idle got %b want 1", fire_ready);
      end
   endtask

   task automatic test_reset_midway;
      p_direction = 2'b01;
      tick(2);
      Reset = 1'b1;
      #1;
      vectors++;
      if ({rotating, cur_direction, BarrelX, BarrelY, MuzzleX} !== {1'b0, 2'b11, 30'd0}) begin
         miscompares++;
         $display("FAIL rst_rot got rot %b dir %b barrel %0d,%0d muz %0d want 0 11 0,0 0",
                  rotating, cur_direction, BarrelX, BarrelY, MuzzleX);
      end
      p_direction = 2'b11;
      tick(1);
      Reset = 1'b0;
      tick(1);
      fire = 1'b1;
      tick(1);
      fire = 1'b0;
      tick(2);
      Reset = 1'b1;
      #1;
      vectors++;
      if ({shot_fire, BarrelY, Barrel_Height_Halved, cur_direction, fire_ready}
          !== {1'b0, 20'd0, 2'b11, 1'b1}) begin
         miscompares++;
         $display("FAIL rst_shot got shot %b y %0d hgt %0d dir %b ready %b want 0 0 0 11 1",
                  shot_fire, BarrelY, Barrel_Height_Halved, cur_direction, fire_ready);
      end
   endtask

   task automatic test_wrap;
      BallX = 10'd5;
      p_direction = 2'b00;
      tick(1);
      Reset = 1'b0;
      tick(5);
      vectors++;
      if (cur_direction !== 2'b00) begin
         miscompares++;
         $display("FAIL wrap_dir got %b want 00", cur_direction);
      end
      tick(1);
      vectors++;
      if ({BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY}
          !== {10'd1010, 10'd240, 10'd4, 10'd6, 10'd1006, 10'd240}) begin
         miscompares++;
         $display("FAIL geom_wrap got %0d,%0d %0d %0d muz %0d,%0d want 1010,240 4 6 muz 1006,240",
                  BarrelX, BarrelY, Barrel_Length_Halved, Barrel_Height_Halved, MuzzleX, MuzzleY);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_rotate_quarter();
      test_rotate_half();
      test_single_shot();
      test_back_to_back();
      test_reset_midway();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
